// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, NOP encoding and reset PC default.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   localparam logic [15:0] NOP_INSTR        = 16'h0000;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   // Word-address increment; wraps 16'hFFFF to 16'h0000.
   function automatic logic [15:0] addr_inc(input logic [15:0] addr);
      return addr + 16'd1;
   endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register holding instruction, its PC and a valid flag.
// Latency: 1 cycle from load/clear to outputs.
// Backpressure: holds contents whenever neither load nor clear is asserted.
module ifid_register
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] load_instr,
   input  logic [15:0] load_pc,
   output logic [15:0] instr,
   output logic [15:0] pc,
   output logic        valid
);

   // Load wins over clear; a clear turns the slot into a bubble but keeps the PC for debug visibility.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instr <= NOP_INSTR;
         pc    <= 16'h0000;
         valid <= 1'b0;
      end else if (load) begin
         instr <= load_instr;
         pc    <= load_pc;
         valid <= 1'b1;
      end else if (clear) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues word requests, handles stall/branch/halt and fills IF/ID.
// Latency: IF/ID updated the cycle after the memory response (or after stall release from HOLD).
// Backpressure: stall parks an accepted response in a hold buffer; requests are never withdrawn.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [15:0] branchTarget,
   input  logic        halt,
   input  logic        imemValid,
   input  logic [15:0] imemData,
   output logic        imemReq,
   output logic [15:0] imemAddr,
   output logic [15:0] pcNext,
   output logic        pcWrite,
   output logic [15:0] ifidInstr,
   output logic [15:0] ifidPc,
   output logic        ifidValid
);

   fetch_state_t state, state_next;
   logic [15:0]  req_addr, req_addr_next;
   logic [15:0]  hold_instr, hold_instr_next;
   logic [15:0]  hold_pc, hold_pc_next;
   logic [15:0]  redirect_addr, redirect_addr_next;
   logic         halt_pending, halt_pending_next;
   logic         halt_active;

   logic         ifid_load;
   logic         ifid_clear;
   logic [15:0]  ifid_load_instr;
   logic [15:0]  ifid_load_pc;

   // A halt seen this cycle counts immediately, later cycles rely on the sticky flag.
   assign halt_active = halt | halt_pending;

   assign imemReq  = (state == FETCH) || (state == DRAIN);
   assign imemAddr = req_addr;

   // Next-state and IF/ID control; priority is halt completion, then branch, then stall.
   always_comb begin
      state_next         = state;
      req_addr_next      = req_addr;
      hold_instr_next    = hold_instr;
      hold_pc_next       = hold_pc;
      redirect_addr_next = redirect_addr;
      halt_pending_next  = halt_pending | halt;
      pcWrite            = 1'b0;
      pcNext             = req_addr;
      ifid_load          = 1'b0;
      ifid_clear         = 1'b0;
      ifid_load_instr    = imemData;
      ifid_load_pc       = req_addr;

      case (state)
         FETCH: begin
            if (imemValid && halt_active) begin
               state_next = HALTED;
            end else if (branchTaken) begin
               pcWrite    = 1'b1;
               pcNext     = branchTarget;
               ifid_clear = 1'b1;
               if (imemValid) begin
                  req_addr_next = branchTarget;
               end else begin
                  // The in-flight request must still complete; remember where to go after it.
                  redirect_addr_next = branchTarget;
                  state_next         = DRAIN;
               end
            end else if (imemValid && stall) begin
               hold_instr_next = imemData;
               hold_pc_next    = req_addr;
               state_next      = HOLD;
            end else if (imemValid) begin
               ifid_load     = 1'b1;
               pcWrite       = 1'b1;
               pcNext        = addr_inc(req_addr);
               req_addr_next = addr_inc(req_addr);
            end else if (!stall) begin
               ifid_clear = 1'b1;
            end
         end

         HOLD: begin
            if (halt_active) begin
               state_next = HALTED;
            end else if (branchTaken) begin
               pcWrite       = 1'b1;
               pcNext        = branchTarget;
               ifid_clear    = 1'b1;
               req_addr_next = branchTarget;
               state_next    = FETCH;
            end else if (!stall) begin
               ifid_load       = 1'b1;
               ifid_load_instr = hold_instr;
               ifid_load_pc    = hold_pc;
               pcWrite         = 1'b1;
               pcNext          = addr_inc(hold_pc);
               req_addr_next   = addr_inc(hold_pc);
               state_next      = FETCH;
            end
         end

         DRAIN: begin
            if (imemValid && halt_active) begin
               state_next = HALTED;
            end else if (branchTaken) begin
               pcWrite    = 1'b1;
               pcNext     = branchTarget;
               ifid_clear = 1'b1;
               if (imemValid) begin
                  req_addr_next = branchTarget;
                  state_next    = FETCH;
               end else begin
                  redirect_addr_next = branchTarget;
               end
            end else begin
               ifid_clear = !stall;
               if (imemValid) begin
                  req_addr_next = redirect_addr;
                  state_next    = FETCH;
               end
            end
         end

         HALTED: begin
            state_next = HALTED;
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Fetch state registers; reset abandons any outstanding request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= FETCH;
         req_addr      <= RESET_PC;
         hold_instr    <= NOP_INSTR;
         hold_pc       <= 16'h0000;
         redirect_addr <= 16'h0000;
         halt_pending  <= 1'b0;
      end else begin
         state         <= state_next;
         req_addr      <= req_addr_next;
         hold_instr    <= hold_instr_next;
         hold_pc       <= hold_pc_next;
         redirect_addr <= redirect_addr_next;
         halt_pending  <= halt_pending_next;
      end
   end

   ifid_register u_ifid (
      .clock      (clock),
      .reset      (reset),
      .load       (ifid_load),
      .clear      (ifid_clear),
      .load_instr (ifid_load_instr),
      .load_pc    (ifid_load_pc),
      .instr      (ifidInstr),
      .pc         (ifidPc),
      .valid      (ifidValid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main flow plus an async-reset-in-HOLD sequence.
// Latency: inputs driven at negedge, combinational outputs sampled 1ns later, IF/ID sampled 1ns after posedge.
// Backpressure: exercised through stall, branch-drain and halt vectors.
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branchTaken;
   logic [15:0] branchTarget;
   logic        halt;
   logic        imemValid;
   logic [15:0] imemData;
   logic        imemReq;
   logic [15:0] imemAddr;
   logic [15:0] pcNext;
   logic        pcWrite;
   logic [15:0] ifidInstr;
   logic [15:0] ifidPc;
   logic        ifidValid;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .halt         (halt),
      .imemValid    (imemValid),
      .imemData     (imemData),
      .imemReq      (imemReq),
      .imemAddr     (imemAddr),
      .pcNext       (pcNext),
      .pcWrite      (pcWrite),
      .ifidInstr    (ifidInstr),
      .ifidPc       (ifidPc),
      .ifidValid    (ifidValid)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        halt;
      logic        vld;
      logic [15:0] dat;
      logic        req;
      logic [15:0] addr;
      logic        pw;
      logic [15:0] pn;
      logic        ifv;
      logic        ckpc;
      logic [15:0] ifpc;
      logic [15:0] ifinstr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t, input logic h,
                               input logic v, input logic [15:0] d, input logic rq, input logic [15:0] a,
                               input logic w, input logic [15:0] n, input logic iv, input logic cp,
                               input logic [15:0] ip, input logic [15:0] ii);
      vec_t r;
      r.stall = s; r.br = b; r.tgt = t; r.halt = h; r.vld = v; r.dat = d;
      r.req = rq; r.addr = a; r.pw = w; r.pn = n; r.ifv = iv; r.ckpc = cp; r.ifpc = ip; r.ifinstr = ii;
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic b, input logic [15:0] t, input logic h,
                        input logic v, input logic [15:0] d);
      stall = s; branchTaken = b; branchTarget = t; halt = h; imemValid = v; imemData = d;
   endtask

   initial begin
      //              stall br tgt      halt vld dat       req addr     pw pn       ifv ck ifpc     ifinstr
      // zero-latency fetch 0..4
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA000, 1, 16'h0000, 1, 16'h0001, 1, 1, 16'h0000, 16'hA000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA001, 1, 16'h0001, 1, 16'h0002, 1, 1, 16'h0001, 16'hA001));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA002, 1, 16'h0002, 1, 16'h0003, 1, 1, 16'h0002, 16'hA002));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA003, 1, 16'h0003, 1, 16'h0004, 1, 1, 16'h0003, 16'hA003));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA004, 1, 16'h0004, 1, 16'h0005, 1, 1, 16'h0004, 16'hA004));
      // stall in response cycle at 5, held 3 cycles, then release
      vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'hA005, 1, 16'h0005, 0, 16'h0000, 1, 1, 16'h0004, 16'hA004));
      vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0005, 0, 16'h0000, 1, 1, 16'h0004, 16'hA004));
      vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0005, 0, 16'h0000, 1, 1, 16'h0004, 16'hA004));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0005, 1, 16'h0006, 1, 1, 16'h0005, 16'hA005));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA006, 1, 16'h0006, 1, 16'h0007, 1, 1, 16'h0006, 16'hA006));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA007, 1, 16'h0007, 1, 16'h0008, 1, 1, 16'h0007, 16'hA007));
      // 2-cycle memory at 8, branch to 0x0040 while outstanding
      vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 1, 16'h0040, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hDEAD, 1, 16'h0008, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hA040, 1, 16'h0040, 1, 16'h0041, 1, 1, 16'h0040, 16'hA040));
      // branch with response to 0xFFFF, then wrap
      vecs.push_back(mk(0, 1, 16'hFFFF, 0, 1, 16'hBEEF, 1, 16'h0041, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hAFFF, 1, 16'hFFFF, 1, 16'h0000, 1, 1, 16'hFFFF, 16'hAFFF));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hB000, 1, 16'h0000, 1, 16'h0001, 1, 1, 16'h0000, 16'hB000));
      // halt while request at 1 outstanding; IF/ID held by stall, response then ends fetching
      vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 1, 1, 16'h0000, 16'hB000));
      vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 1, 1, 16'h0000, 16'hB000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hC001, 1, 16'h0001, 0, 16'h0000, 1, 1, 16'h0000, 16'hB000));
      vecs.push_back(mk(0, 1, 16'h1234, 0, 1, 16'hC002, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'hB000));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'hB000));

      reset = 1'b0;
      drive(0, 0, 16'h0000, 0, 0, 16'h0000);
      #3;
      check("reset ifidValid", {15'd0, ifidValid}, 16'h0000);
      check("reset ifidPc", ifidPc, 16'h0000);
      check("reset ifidInstr", ifidInstr, 16'h0000);
      check("reset pcWrite", {15'd0, pcWrite}, 16'h0000);
      check("reset pcNext", pcNext, 16'h0000);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].halt, vecs[i].vld, vecs[i].dat);
         #1;
         check($sformatf("v%0d imemReq", i), {15'd0, imemReq}, {15'd0, vecs[i].req});
         if (vecs[i].req)
            check($sformatf("v%0d imemAddr", i), imemAddr, vecs[i].addr);
         check($sformatf("v%0d pcWrite", i), {15'd0, pcWrite}, {15'd0, vecs[i].pw});
         if (vecs[i].pw)
            check($sformatf("v%0d pcNext", i), pcNext, vecs[i].pn);
         @(posedge clock);
         #1;
         check($sformatf("v%0d ifidValid", i), {15'd0, ifidValid}, {15'd0, vecs[i].ifv});
         if (vecs[i].ckpc) begin
            check($sformatf("v%0d ifidPc", i), ifidPc, vecs[i].ifpc);
            check($sformatf("v%0d ifidInstr", i), ifidInstr, vecs[i].ifinstr);
         end
         @(negedge clock);
      end

      // Reset asserted while parked in HOLD: fresh restart, fetch 0 and 1, stall response at 2.
      reset = 1'b0;
      drive(0, 0, 16'h0000, 0, 0, 16'h0000);
      @(negedge clock);
      reset = 1'b1;
      drive(0, 0, 16'h0000, 0, 1, 16'h5A00);
      #1;
      check("rst2 first imemAddr", imemAddr, 16'h0000);
      @(negedge clock);
      drive(0, 0, 16'h0000, 0, 1, 16'h5A01);
      @(negedge clock);
      drive(1, 0, 16'h0000, 0, 1, 16'h5A02);
      @(negedge clock);
      drive(1, 0, 16'h0000, 0, 0, 16'h0000);
      #1;
      check("hold imemReq", {15'd0, imemReq}, 16'h0000);
      check("hold ifidPc", ifidPc, 16'h0001);
      check("hold ifidValid", {15'd0, ifidValid}, 16'h0001);
      #1;
      reset = 1'b0;
      #1;
      check("async ifidValid", {15'd0, ifidValid}, 16'h0000);
      check("async ifidPc", ifidPc, 16'h0000);
      check("async ifidInstr", ifidInstr, 16'h0000);
      check("async pcWrite", {15'd0, pcWrite}, 16'h0000);
      check("async pcNext", pcNext, 16'h0000);
      @(negedge clock);
      reset = 1'b1;
      drive(0, 0, 16'h0000, 0, 1, 16'h6000);
      #1;
      check("restart imemReq", {15'd0, imemReq}, 16'h0001);
      check("restart imemAddr", imemAddr, 16'h0000);
      check("restart pcNext", pcNext, 16'h0001);
      @(posedge clock);
      #1;
      check("restart ifidPc", ifidPc, 16'h0000);
      check("restart ifidInstr", ifidInstr, 16'h6000);
      check("restart ifidValid", {15'd0, ifidValid}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
